inst_loader: RTL and testbench



---
 rtl/inst_loader_pkg.sv | 23 ++
 rtl/inst_loader_byte_assembler.sv | 34 +++
 rtl/inst_loader.sv | 120 ++++++++++++
 tb/tb_inst_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package inst_loader_pkg;

  // Every header field (start address, word count, checksum) and data word is 32 bits.
  localparam int HDR_FIELD_W = 32;

  typedef enum logic [2:0] {
    LDR_HDR_ADDR = 3'd0,
    LDR_HDR_CNT  = 3'd1,
    LDR_DATA     = 3'd2,
    LDR_CHK      = 3'd3,
    LDR_DONE     = 3'd4,
    LDR_ERR      = 3'd5
  } ldr_state_e;

  // Single-cycle write into instruction RAM.
  typedef struct packed {
    logic                   we;
    logic [HDR_FIELD_W-1:0] addr;
    logic [HDR_FIELD_W-1:0] data;
  } imem_wr_t;

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Packs four accepted bytes, LSB first, into a 32-bit word. word_valid is
// combinational on the 4th byte so the parent can act on the accepting edge.
module byte_assembler
  import inst_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   word_valid,
  output logic [HDR_FIELD_W-1:0] word
);

  logic [1:0]  cnt_q;
  logic [23:0] shreg_q;   // only the first three bytes need storing

  assign word_valid = in_valid && (cnt_q == 2'd3);
  assign word       = {in_data, shreg_q};

  // Byte counter and shift register; bytes enter at the top so the first lands in [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      shreg_q <= '0;
    end else if (clr) begin
      cnt_q   <= 2'd0;
    end else if (in_valid) begin
      cnt_q   <= cnt_q + 2'd1;
      shreg_q <= {in_data, shreg_q[23:8]};
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot loader: parses {start addr, word count, data words} from a byte stream,
// writes instruction RAM and holds the core until the image is complete.
// Optional trailing 32-bit checksum check when LOADER_CHECKSUM_EN is defined.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  input  logic        i_reload,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_data,
  output logic        o_core_hold,
  output logic [31:0] o_start_addr,
  output logic        o_start_valid,
  output logic        o_err
);

`ifdef LOADER_CHECKSUM_EN
  localparam ldr_state_e FINAL_ST = LDR_CHK;
`else
  localparam ldr_state_e FINAL_ST = LDR_DONE;
`endif

  ldr_state_e             state_q, state_d;
  logic                   accept, wv, restart, last_word;
  logic [HDR_FIELD_W-1:0] word, cnt_q, widx_q;
  imem_wr_t               wr_q;

  assign accept    = i_rx_valid && o_rx_ready;
  assign restart   = i_reload && (state_q == LDR_DONE || state_q == LDR_ERR);
  assign last_word = (widx_q == cnt_q - 32'd1);

  assign o_imem_we   = wr_q.we;
  assign o_imem_addr = wr_q.addr;
  assign o_imem_data = wr_q.data;

  byte_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (restart),
    .in_valid   (accept),
    .in_data    (i_rx_data),
    .word_valid (wv),
    .word       (word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [HDR_FIELD_W-1:0] sum_q;

  // Running modular sum of data words for the trailing checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         sum_q <= '0;
    else if (restart)                   sum_q <= '0;
    else if (state_q == LDR_DATA && wv) sum_q <= sum_q + word;
  end
`endif

  // Next-state decode; every field completes on the edge accepting its 4th byte.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LDR_HDR_ADDR: if (wv) state_d = (word[1:0] != 2'b00) ? LDR_ERR : LDR_HDR_CNT;
      LDR_HDR_CNT: if (wv) begin
        if (word > 32'(IMEM_DEPTH)) state_d = LDR_ERR;
        else if (word == '0)        state_d = FINAL_ST;
        else                        state_d = LDR_DATA;
      end
      LDR_DATA: if (wv && last_word) state_d = FINAL_ST;
`ifdef LOADER_CHECKSUM_EN
      LDR_CHK: if (wv) state_d = (word == sum_q) ? LDR_DONE : LDR_ERR;
`endif
      LDR_DONE, LDR_ERR: if (i_reload) state_d = LDR_HDR_ADDR;
      default: state_d = LDR_HDR_ADDR;
    endcase
  end

  // State, header fields and registered status outputs (decoded from next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LDR_HDR_ADDR;
      o_start_addr  <= '0;
      cnt_q         <= '0;
      o_rx_ready    <= 1'b1;
      o_core_hold   <= 1'b1;
      o_start_valid <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      state_q       <= state_d;
      if (state_q == LDR_HDR_ADDR && wv) o_start_addr <= word;
      if (state_q == LDR_HDR_CNT  && wv) cnt_q        <= word;
      o_rx_ready    <= !(state_d == LDR_DONE || state_d == LDR_ERR);
      o_core_hold   <= (state_d != LDR_DONE);
      o_start_valid <= (state_d == LDR_DONE);
      o_err         <= (state_d == LDR_ERR);
    end
  end

  // RAM write one cycle after a data word completes; address wraps modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      widx_q <= '0;
    end else begin
      wr_q.we <= (state_q == LDR_DATA) && wv;
      if (restart) widx_q <= '0;
      if (state_q == LDR_DATA && wv) begin
        wr_q.addr <= o_start_addr + {widx_q[29:0], 2'b00};
        wr_q.data <= word;
        widx_q    <= widx_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with a write scoreboard; checksum steps run
// only when LOADER_CHECKSUM_EN is defined.
module tb_inst_loader;
  localparam int DEPTH = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_valid = 1'b0, i_reload = 1'b0;
  logic        o_rx_ready, o_imem_we, o_core_hold, o_start_valid, o_err;
  logic [31:0] o_imem_addr, o_imem_data, o_start_addr;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] img[$];
  int          nchk = 0, nerr = 0;

  inst_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_rx_ready(o_rx_ready), .i_reload(i_reload), .o_imem_we(o_imem_we),
    .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data), .o_core_hold(o_core_hold),
    .o_start_addr(o_start_addr), .o_start_valid(o_start_valid), .o_err(o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every RAM write must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_imem_we === 1'b1) begin
      chk("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", o_imem_addr, e.addr);
        chk("wr_data", o_imem_data, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    while (o_rx_ready !== 1'b1 && t < 16) begin @(negedge clk); t++; end
    if (t == 16) chk("rx_ready_timeout", {31'd0, o_rx_ready}, 32'd1);
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap, input bit is_data);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (i == 3 && is_data) chk("we_latency", {31'd0, o_imem_we}, 32'd1);
      if (gap) begin
        @(negedge clk);
        if (i == 3 && is_data) chk("we_one_cycle", {31'd0, o_imem_we}, 32'd0);
      end
    end
  endtask

  // Full image from img[]: header, data words, and checksum when enabled.
  task automatic load(input logic [31:0] addr, input logic [31:0] n, input bit gap);
    logic [31:0] sum = '0;
    wr_t e;
    send_word(addr, gap, 1'b0);
    send_word(n, gap, 1'b0);
    for (int k = 0; k < int'(n); k++) begin
      e.addr = addr + 32'(4 * k);
      e.data = img[k];
      exp_q.push_back(e);
      sum += img[k];
      send_word(img[k], gap, 1'b1);
    end
`ifdef LOADER_CHECKSUM_EN
    send_word(sum, gap, 1'b0);
`endif
  endtask

  task automatic check_done(input logic [31:0] addr);
    chk("done_start_valid", {31'd0, o_start_valid}, 32'd1);
    chk("done_core_hold",   {31'd0, o_core_hold},   32'd0);
    chk("done_start_addr",  o_start_addr,           addr);
    chk("done_rx_ready",    {31'd0, o_rx_ready},    32'd0);
    chk("done_err",         {31'd0, o_err},         32'd0);
  endtask

  task automatic check_err();
    chk("err_flag",        {31'd0, o_err},         32'd1);
    chk("err_core_hold",   {31'd0, o_core_hold},   32'd1);
    chk("err_rx_ready",    {31'd0, o_rx_ready},    32'd0);
    chk("err_start_valid", {31'd0, o_start_valid}, 32'd0);
  endtask

  task automatic check_reset_vals();
    chk("rst_rx_ready",    {31'd0, o_rx_ready},    32'd1);
    chk("rst_imem_we",     {31'd0, o_imem_we},     32'd0);
    chk("rst_imem_addr",   o_imem_addr,            32'd0);
    chk("rst_imem_data",   o_imem_data,            32'd0);
    chk("rst_core_hold",   {31'd0, o_core_hold},   32'd1);
    chk("rst_start_addr",  o_start_addr,           32'd0);
    chk("rst_start_valid", {31'd0, o_start_valid}, 32'd0);
    chk("rst_err",         {31'd0, o_err},         32'd0);
  endtask

  // Reload pulse with a byte offered in the same cycle; that byte must be dropped.
  task automatic do_reload();
    i_reload   = 1'b1;
    i_rx_valid = 1'b1;
    i_rx_data  = 8'hA5;
    @(negedge clk);
    i_reload   = 1'b0;
    i_rx_valid = 1'b0;
    chk("reload_core_hold",   {31'd0, o_core_hold},   32'd1);
    chk("reload_start_valid", {31'd0, o_start_valid}, 32'd0);
    chk("reload_err",         {31'd0, o_err},         32'd0);
    chk("reload_rx_ready",    {31'd0, o_rx_ready},    32'd1);
  endtask

  initial begin
    wr_t e;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-word image at address 0.
    img = '{32'h0000_0013, 32'h0010_0093};
    load(32'h0, 32'd2, 1'b0);
    check_done(32'h0);
    do_reload();

    // Misaligned start address.
    send_word(32'h0000_0102, 1'b0, 1'b0);
    check_err();
    repeat (3) @(negedge clk);
    chk("err_sticky", {31'd0, o_err}, 32'd1);
    do_reload();

    // Count one above capacity.
    send_word(32'h0, 1'b0, 1'b0);
    send_word(32'(DEPTH + 1), 1'b0, 1'b0);
    check_err();
    do_reload();

    // Count exactly at capacity.
    img.delete();
    for (int k = 0; k < DEPTH; k++) img.push_back($urandom);
    load(32'h200, 32'(DEPTH), 1'b0);
    check_done(32'h200);
    do_reload();

    // Empty image.
    load(32'h40, 32'd0, 1'b0);
    check_done(32'h40);
    do_reload();

    // Valid toggling every other cycle.
    img = '{32'hCAFE_0001, 32'h1234_5678, 32'h8765_4321};
    load(32'h100, 32'd3, 1'b1);
    check_done(32'h100);
    do_reload();

    // Address wraps past 2^32.
    img = '{32'h1111_1111, 32'h2222_2222};
    load(32'hFFFF_FFFC, 32'd2, 1'b0);
    check_done(32'hFFFF_FFFC);
    do_reload();

    // Reset after 2 bytes of the second word, then a fresh image at 0x80.
    send_word(32'h40, 1'b0, 1'b0);
    send_word(32'd2, 1'b0, 1'b0);
    e.addr = 32'h40; e.data = 32'hAAAA_5555;
    exp_q.push_back(e);
    send_word(32'hAAAA_5555, 1'b0, 1'b1);
    send_byte(8'h77);
    send_byte(8'h66);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    img = '{32'hDEAD_BEEF};
    load(32'h80, 32'd1, 1'b0);
    check_done(32'h80);
    do_reload();

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum (correct is 0x001000A6): written words stay, core stays held.
    send_word(32'h0, 1'b0, 1'b0);
    send_word(32'd2, 1'b0, 1'b0);
    e.addr = 32'h0; e.data = 32'h0000_0013; exp_q.push_back(e);
    send_word(32'h0000_0013, 1'b0, 1'b1);
    e.addr = 32'h4; e.data = 32'h0010_0093; exp_q.push_back(e);
    send_word(32'h0010_0093, 1'b0, 1'b1);
    chk("chk_hold_before_sum", {31'd0, o_core_hold}, 32'd1);
    send_word(32'h0010_00A7, 1'b0, 1'b0);
    check_err();
    do_reload();
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
